// File: rtl/axis_rx_pkt_checker.sv
// Sink-side checker for the 64-bit AXIS test packet generator: verifies the beat pattern, tkeep,
// byte length against tuser[15:0] and the packet size, then reports pass/fail with running counters.
module axis_rx_pkt_checker #(
    parameter logic [15:0] P_MAX_BEATS  = 16'd512,
    parameter bit          P_CHECK_DATA = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] s_axis_tdata,
    input  logic [31:0] s_axis_tuser,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        i_hold,
    output logic        o_pkt_ok,
    output logic        o_pkt_err,
    output logic [2:0]  o_err_code,
    output logic [15:0] o_last_len,
    output logic [31:0] o_pkt_cnt,
    output logic [15:0] o_err_cnt,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StBody, StDrain} state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic        r_tready;
    logic [15:0] r_k;
    logic [15:0] r_exp_len;
    logic [2:0]  r_code;
    logic        r_pkt_ok;
    logic        r_pkt_err;
    logic [2:0]  r_err_code;
    logic [15:0] r_last_len;
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_err_cnt;

    logic        w_hs;
    logic [15:0] w_k;
    logic [15:0] w_exp_len;
    logic [3:0]  w_pop;
    logic [15:0] w_meas;
    logic        w_keep_legal;
    logic        w_keep_bad;
    logic        w_len_bad;
    logic        w_data_bad;
    logic        w_over;
    logic [2:0]  w_beat_code;
    logic        w_report;
    logic [2:0]  w_rep_code;
    logic        w_enter_drain;

    assign w_hs = s_axis_tvalid & r_tready;

    // The first beat of a packet arrives in IDLE, so its index and expected length come straight in.
    assign w_k       = (r_state == StIdle) ? 16'd0 : r_k;
    assign w_exp_len = (r_state == StIdle) ? s_axis_tuser[15:0] : r_exp_len;

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, s_axis_tkeep[i]};
        end
    end

    assign w_meas = {w_k[12:0], 3'b000} + {12'd0, w_pop};

    always_comb begin
        w_keep_legal = 1'b0;
        case (s_axis_tkeep)
            8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF: w_keep_legal = 1'b1;
            default:                                                w_keep_legal = 1'b0;
        endcase
    end

    assign w_keep_bad = s_axis_tlast ? ~w_keep_legal : (s_axis_tkeep != 8'hFF);
    assign w_len_bad  = s_axis_tlast & (w_meas != w_exp_len);
    assign w_data_bad = P_CHECK_DATA & (s_axis_tdata != {4{w_k}});
    assign w_over     = ~s_axis_tlast & (w_k == P_MAX_BEATS);

    // Lowest code wins when several checks fail on the same beat.
    always_comb begin
        w_beat_code = 3'd0;
        if (w_keep_bad) begin
            w_beat_code = 3'd1;
        end else if (w_len_bad) begin
            w_beat_code = 3'd2;
        end else if (w_data_bad) begin
            w_beat_code = 3'd3;
        end else if (w_over) begin
            w_beat_code = 3'd4;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_report      = 1'b0;
        w_rep_code    = 3'd0;
        w_enter_drain = 1'b0;
        if (w_hs) begin
            case (r_state)
                StIdle, StBody: begin
                    if (s_axis_tlast) begin
                        w_report   = 1'b1;
                        w_rep_code = w_beat_code;
                        w_state_d  = StIdle;
                    end else if (w_beat_code != 3'd0) begin
                        w_enter_drain = 1'b1;
                        w_state_d     = StDrain;
                    end else begin
                        w_state_d = StBody;
                    end
                end
                StDrain: begin
                    if (s_axis_tlast) begin
                        w_report   = 1'b1;
                        w_rep_code = r_code;
                        w_state_d  = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_tready  <= 1'b0;
            r_k       <= 16'd0;
            r_exp_len <= 16'd0;
            r_code    <= 3'd0;
        end else begin
            r_state  <= w_state_d;
            r_tready <= ~i_hold;
            if (w_hs) begin
                r_k <= w_k + 16'd1;
                if (r_state == StIdle) begin
                    r_exp_len <= s_axis_tuser[15:0];
                end
            end
            if (w_enter_drain) begin
                r_code <= w_beat_code;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= 3'd0;
            r_last_len <= 16'd0;
            r_pkt_cnt  <= 32'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            r_pkt_ok  <= 1'b0;
            r_pkt_err <= 1'b0;
            if (w_report) begin
                r_pkt_ok   <= (w_rep_code == 3'd0);
                r_pkt_err  <= (w_rep_code != 3'd0);
                r_err_code <= w_rep_code;
                r_last_len <= w_meas;
                if (r_pkt_cnt != 32'hFFFF_FFFF) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
                if ((w_rep_code != 3'd0) && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign o_pkt_ok      = r_pkt_ok;
    assign o_pkt_err     = r_pkt_err;
    assign o_err_code    = r_err_code;
    assign o_last_len    = r_last_len;
    assign o_pkt_cnt     = r_pkt_cnt;
    assign o_err_cnt     = r_err_cnt;
    assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_axis_rx_pkt_checker.sv
// Bench for axis_rx_pkt_checker: directed and randomized packets, each judged by a whole-packet
// reference model and compared report-by-report.
module tb_axis_rx_pkt_checker;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [31:0] s_axis_tuser = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        i_hold = 1'b0;
    logic        o_pkt_ok;
    logic        o_pkt_err;
    logic [2:0]  o_err_code;
    logic [15:0] o_last_len;
    logic [31:0] o_pkt_cnt;
    logic [15:0] o_err_cnt;
    logic        o_busy;

    axis_rx_pkt_checker dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .i_hold        (i_hold),
        .o_pkt_ok      (o_pkt_ok),
        .o_pkt_err     (o_pkt_err),
        .o_err_code    (o_err_code),
        .o_last_len    (o_last_len),
        .o_pkt_cnt     (o_pkt_cnt),
        .o_err_cnt     (o_err_cnt),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        ok;
        logic        err;
        logic [2:0]  code;
        logic [15:0] len;
        logic [31:0] pcnt;
        logic [15:0] ecnt;
    } rpt_t;

    localparam int MAX_BEATS = 512;

    int          checks = 0;
    int          errors = 0;
    int          hold_mode = 0;
    bit          gaps = 1'b0;
    int unsigned m_pcnt = 0;
    int unsigned m_ecnt = 0;
    logic [63:0] dat[$];
    logic [7:0]  kep[$];
    logic [31:0] usr;
    rpt_t        exp_q[$];
    rpt_t        got_q[$];

    always @(negedge i_clk) begin
        if (o_pkt_ok || o_pkt_err) begin
            got_q.push_back('{ok: o_pkt_ok, err: o_pkt_err, code: o_err_code, len: o_last_len,
                              pcnt: o_pkt_cnt, ecnt: o_err_cnt});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        case (hold_mode)
            1:       i_hold = ~i_hold;
            2:       i_hold = ($urandom_range(0, 3) == 0);
            default: i_hold = 1'b0;
        endcase
    endtask

    // Whole-packet judgement: scan beats in order, first failing rule decides the code.
    function automatic rpt_t model(input int n);
        logic [15:0] meas;
        logic [2:0]  c;
        bit          last;
        c    = 3'd0;
        meas = 16'(8 * (n - 1) + $countones(kep[n-1]));
        for (int i = 0; i < n && c == 3'd0; i++) begin
            last = (i == n - 1);
            if (last ? !(kep[i] inside {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF})
                     : (kep[i] != 8'hFF))
                c = 3'd1;
            else if (last && meas != usr[15:0])
                c = 3'd2;
            else if (dat[i] != {4{16'(i)}})
                c = 3'd3;
            else if (!last && i == MAX_BEATS)
                c = 3'd4;
        end
        m_pcnt++;
        if (c != 3'd0) m_ecnt++;
        model = '{ok: (c == 3'd0), err: (c != 3'd0), code: c, len: meas,
                  pcnt: m_pcnt, ecnt: 16'(m_ecnt)};
    endfunction

    task automatic build(input int n, input logic [7:0] last_keep, input int len_delta);
        dat.delete();
        kep.delete();
        for (int i = 0; i < n; i++) begin
            dat.push_back({4{16'(i)}});
            kep.push_back((i == n - 1) ? last_keep : 8'hFF);
        end
        usr = {16'($urandom), 16'(8 * (n - 1) + $countones(last_keep) + len_delta)};
    endtask

    task automatic drive_beat(input int i, input int n);
        int tries = 0;
        bit acc = 1'b0;
        if (gaps && $urandom_range(0, 7) == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'($urandom);
            tick();
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = dat[i];
        s_axis_tkeep  = kep[i];
        s_axis_tlast  = (i == n - 1);
        s_axis_tuser  = usr;
        while (!acc && tries < 64) begin
            @(negedge i_clk);
            acc = s_axis_tready;
            tick();
            tries++;
        end
        if (!acc) begin
            chk("beat_accept", {31'd0, acc}, 32'd1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "FAIL beat_accept stalled");
        end
    endtask

    task automatic send_pkt(input int n);
        exp_q.push_back(model(n));
        for (int i = 0; i < n; i++) drive_beat(i, n);
    endtask

    task automatic check_reports(input string tag);
        int t = 0;
        int m;
        s_axis_tvalid = 1'b0;
        while (got_q.size() < exp_q.size() && t < 40) begin
            tick();
            t++;
        end
        tick();
        tick();
        chk($sformatf("%s.nrpt", tag), got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s[%0d].ok", tag, i), {31'd0, got_q[i].ok}, {31'd0, exp_q[i].ok});
            chk($sformatf("%s[%0d].err", tag, i), {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
            chk($sformatf("%s[%0d].code", tag, i), {29'd0, got_q[i].code}, {29'd0, exp_q[i].code});
            chk($sformatf("%s[%0d].len", tag, i), {16'd0, got_q[i].len}, {16'd0, exp_q[i].len});
            chk($sformatf("%s[%0d].pcnt", tag, i), got_q[i].pcnt, exp_q[i].pcnt);
            chk($sformatf("%s[%0d].ecnt", tag, i), {16'd0, got_q[i].ecnt}, {16'd0, exp_q[i].ecnt});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".tready"}, {31'd0, s_axis_tready}, 32'd0);
        chk({tag, ".ok"}, {31'd0, o_pkt_ok}, 32'd0);
        chk({tag, ".err"}, {31'd0, o_pkt_err}, 32'd0);
        chk({tag, ".code"}, {29'd0, o_err_code}, 32'd0);
        chk({tag, ".len"}, {16'd0, o_last_len}, 32'd0);
        chk({tag, ".pcnt"}, o_pkt_cnt, 32'd0);
        chk({tag, ".ecnt"}, {16'd0, o_err_cnt}, 32'd0);
        chk({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] legal [8];
        int n;
        int kind;
        int j;
        legal = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("tready_after_release", {31'd0, s_axis_tready}, 32'd0);
        tick();

        build(408, 8'hFE, 0);
        send_pkt(408);
        check_reports("len_ok");

        build(408, 8'hFE, 1);
        send_pkt(408);
        check_reports("len_bad");

        build(408, 8'hFE, 0);
        kep[5] = 8'h7F;
        send_pkt(408);
        check_reports("keep_bad");

        build(600, 8'hFF, 0);
        send_pkt(600);
        check_reports("oversize");

        build(1, 8'hC0, 0);
        send_pkt(1);
        check_reports("one_beat");

        hold_mode = 1;
        for (int p = 0; p < 20; p++) begin
            build(408, 8'hFE, 0);
            send_pkt(408);
        end
        check_reports("b2b_hold");

        hold_mode = 2;
        gaps = 1'b1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 24);
            build(n, legal[$urandom_range(0, 7)], 0);
            kind = $urandom_range(0, 3);
            j = $urandom_range(0, n - 1);
            case (kind)
                1: kep[j] = (j == n - 1) ? 8'($urandom) : (8'hFF ^ (8'h1 << $urandom_range(0, 7)));
                2: usr[15:0] = usr[15:0] + 16'($urandom_range(1, 20));
                3: dat[j] = dat[j] ^ (64'h1 << $urandom_range(0, 63));
                default: ;
            endcase
            send_pkt(n);
            if (p % 4 == 3) check_reports($sformatf("rand%0d", p));
        end
        check_reports("rand_tail");

        hold_mode = 0;
        gaps = 1'b0;
        build(408, 8'hFE, 0);
        for (int i = 0; i < 200; i++) drive_beat(i, 408);
        s_axis_tvalid = 1'b0;
        @(negedge i_clk);
        chk("busy_mid_pkt", {31'd0, o_busy}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        m_pcnt = 0;
        m_ecnt = 0;
        got_q.delete();
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("tready_after_rerelease", {31'd0, s_axis_tready}, 32'd0);
        tick();
        build(30, 8'hF8, 0);
        send_pkt(30);
        check_reports("fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
